data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Two-master arbiter for the single-port 8-bit data RAM in the Harvard micro system. Master 0 is the `MicroBitos` data bus and master 1 is a second requester (host loader/debug or DMA). The arbiter serialises their accesses with a req/gnt handshake, drives the RAM address, data and write strobe, and routes read data back with a registered valid. It uses round-robin ownership with a bounded burst length, so neither master can starve the other.

## Interface
- `ADDR_W`, 8, address width (matches RAM `i_Address`)
- `DATA_W`, 8, data width
- `MAX_BURST`, 4, max consecutive granted transfers per ownership while the other master is requesting (≥1)

- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  synchronous, active-low reset
- `m0_req`, `m1_req`  in  1  access request, held until granted
- `m0_addr`, `m1_addr`  in  ADDR_W  access address
- `m0_wdata`, `m1_wdata`  in  DATA_W  write data
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read
- `m0_gnt`, `m1_gnt`  out  1  transfer accepted this cycle
- `m0_rvalid`, `m1_rvalid`  out  1  read data valid (cycle after granted read)
- `m0_rdata`, `m1_rdata`  out  DATA_W  read data, meaningful only with rvalid
- `ram_addr`  out  ADDR_W  to RAM `i_Address`
- `ram_wdata`  out  DATA_W  to RAM `i_DataIn`
- `ram_we`  out  1  to RAM `i_WR`
- `ram_rdata`  in  DATA_W  from RAM `o_DataOut`, valid one cycle after address
- `owner`  out  2  debug: 00 idle, 01 m0, 10 m1

## Operation
- FSM states: IDLE, OWN0, OWN1. Registers: state, `last` (last owner, 0 = m0), `burst_cnt`, `rd_pend`, `rd_tag`.
- IDLE: no grants. One req → OWN of that master. Both → master ≠ `last`. After reset `last`=1, so m0 wins the first tie. None → stay.
- OWNk: `mk_gnt = mk_req`, and the other gnt = 0. On each grant `burst_cnt++`.
- Leaving OWNk, evaluated every cycle in priority order:
  - (a) `mk_req`=0 and other req=1 → OWN other.
  - (b) `mk_req`=0 and other req=0 → IDLE.
  - (c) grant this cycle with `burst_cnt+1 == MAX_BURST` and other req=1 → OWN other.
  - (d) otherwise stay.
  - On every transition, `last` ← k and `burst_cnt` ← 0.
- With no competition, the owner keeps ownership indefinitely. `burst_cnt` saturates at `MAX_BURST-1`.
- RAM drive:
  - `ram_addr`/`ram_wdata` = granted master's signals; 0 when no grant.
  - `ram_we` = gnt & we.
  - All of these are combinational from state and inputs.
- Read return: granted read sets `rd_pend`=1 and `rd_tag`=k for one cycle. Next cycle `mk_rvalid`=1 and `mk_rdata` = `ram_rdata`, passed through. Otherwise `rdata` = 0.
- Writes produce no rvalid.
- Simultaneous read return to m0 and new grant to m1 is legal: pipelined, no bubble.

## Timing
- Reset (`reset`=0 at a clock edge): state IDLE, `last`=1, `burst_cnt`=0, `rd_pend`=0.
- Outputs in reset: all gnt/rvalid/`ram_we` = 0, `ram_addr`/`ram_wdata`/rdata = 0, `owner`=00.
- Reset mid-burst aborts ownership. A pending rvalid is dropped.
- Latency from req while IDLE: gnt in the next cycle (one arbitration cycle).
- Back-to-back grants to the owner: every cycle.
- Handover between masters: zero dead cycles via (c). Via (a) there is one cycle with no grant.
- Read: data at master 1 cycle after gnt.
- No combinational path from `ram_rdata` to any gnt.

## Structure
- Package `mem_arb_pkg`: state enum (IDLE/OWN0/OWN1), owner codes, default widths.
- Single module. No sub-module needed. Round-robin pick is a few lines in the FSM next-state logic.
- Inserted in the system top between the micro data bus and the RAM. The micro holds its access while `m0_gnt` is low.

## Test plan
- Reset release, m0 read of addr 0x10 (RAM holds 0x5A) → `m0_gnt` in cycle 1, `m0_rvalid`=1 with `m0_rdata`=0x5A in cycle 2, `owner`=01.
- Both masters assert req on the same cycle after reset, `MAX_BURST`=4, continuous → m0 granted 4 cycles, then m1 4 cycles, alternating, no idle cycles.
- m1 writes 0xA5 to 0x20, then m0 reads 0x20 → `ram_we` only in m1's gnt cycle, and m0 gets 0xA5.
- m0 drops req while m1 requests → one cycle with no grant, then `m1_gnt`.
- Both idle → IDLE, `ram_we`=0, `ram_addr`=0.
- `reset` low during an m1 burst with a read pending → next cycle all outputs 0, and no `m1_rvalid`.
- After release, a simultaneous req → m0 wins.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
//   Shared types and constants for the two-master data RAM arbiter.
//   - arb_state_e : arbitration FSM state (idle / master 0 owns / master 1 owns)
//   - OWNER_*     : encoding of the debug 'owner' output
//   - DEF_*       : default widths and burst limit used by data_mem_arbiter
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  localparam logic [1:0] OWNER_IDLE = 2'b00;
  localparam logic [1:0] OWNER_M0   = 2'b01;
  localparam logic [1:0] OWNER_M1   = 2'b10;

  localparam int unsigned DEF_ADDR_W    = 8;
  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_MAX_BURST = 4;

  // Debug owner code for a given arbitration state.
  function automatic logic [1:0] owner_code(arb_state_e st);
    case (st)
      ST_OWN0: owner_code = OWNER_M0;
      ST_OWN1: owner_code = OWNER_M1;
      default: owner_code = OWNER_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//   Serialises accesses of two masters (m0 = micro data bus, m1 = loader/DMA)
//   onto one single-port RAM. Round-robin ownership with a bounded burst:
//   while the other master waits, an owner gets at most MAX_BURST consecutive
//   grants before ownership hands over with no dead cycle.
//
// Ports
//   clk, reset            : clock, synchronous active-low reset
//   mK_req/addr/wdata/we  : master K access request (held until granted)
//   mK_gnt                : master K transfer accepted this cycle
//   mK_rvalid/rdata       : read data for master K, one cycle after its grant
//   ram_addr/wdata/we     : combinational drive of the RAM port
//   ram_rdata             : RAM read data, valid one cycle after the address
//   owner                 : debug, 00 idle / 01 m0 / 10 m1
// -----------------------------------------------------------------------------
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_we,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_we,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        owner
);

  localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  // Saturation value of burst_cnt; reaching it with a grant ends the burst.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_e       state_q, state_d;
  logic             last_q, last_d;          // last owner, 0 = m0
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             rd_pend_q, rd_pend_d;
  logic             rd_tag_q, rd_tag_d;      // master of the pending read

  logic own_is_m1;
  logic own_req;
  logic oth_req;

  assign own_is_m1 = (state_q == ST_OWN1);
  assign own_req   = own_is_m1 ? m1_req : m0_req;
  assign oth_req   = own_is_m1 ? m0_req : m1_req;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of process order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;   // m0 wins the first tie after reset
      burst_cnt_q <= '0;
      rd_pend_q   <= 1'b0;
      rd_tag_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      rd_pend_q   <= rd_pend_d;
      rd_tag_q    <= rd_tag_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: round-robin pick from idle, burst-bounded handover
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default before any branch, so no path through
  // the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (m0_req && m1_req) begin
          state_d = last_q ? ST_OWN0 : ST_OWN1;
        end else if (m0_req) begin
          state_d = ST_OWN0;
        end else if (m1_req) begin
          state_d = ST_OWN1;
        end
      end

      ST_OWN0, ST_OWN1: begin
        if (!own_req) begin
          // Owner released: hand over (one cycle without grant) or go idle.
          state_d     = oth_req ? (own_is_m1 ? ST_OWN0 : ST_OWN1) : ST_IDLE;
          last_d      = own_is_m1;
          burst_cnt_d = '0;
        end else if (burst_cnt_q == CNT_LAST && oth_req) begin
          // Burst exhausted on this grant: the other master is granted next
          // cycle, so the bus never idles.
          state_d     = own_is_m1 ? ST_OWN0 : ST_OWN1;
          last_d      = own_is_m1;
          burst_cnt_d = '0;
        end else if (burst_cnt_q != CNT_LAST) begin
          // Owner is granted this cycle; count saturates when uncontested.
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: grants, RAM drive, read return
  // ---------------------------------------------------------------------------
  // Grants and read-valids are also held low while reset is asserted, so a
  // master never sees a transfer accepted in a cycle that is being discarded.
  always_comb begin
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;

    if (reset) begin
      case (state_q)
        ST_OWN0: m0_gnt = m0_req;
        ST_OWN1: m1_gnt = m1_req;
        default: ;
      endcase
    end

    if (m0_gnt) begin
      ram_addr  = m0_addr;
      ram_wdata = m0_wdata;
      ram_we    = m0_we;
    end else if (m1_gnt) begin
      ram_addr  = m1_addr;
      ram_wdata = m1_wdata;
      ram_we    = m1_we;
    end

    // A granted read returns data next cycle; the tag routes it.
    rd_pend_d = (m0_gnt && !m0_we) || (m1_gnt && !m1_we);
    rd_tag_d  = m1_gnt;

    m0_rvalid = reset && rd_pend_q && !rd_tag_q;
    m1_rvalid = reset && rd_pend_q && rd_tag_q;
    m0_rdata  = m0_rvalid ? ram_rdata : '0;
    m1_rdata  = m1_rvalid ? ram_rdata : '0;

    owner     = reset ? owner_code(state_q) : OWNER_IDLE;
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
//   Directed scenarios followed by random two-master traffic. A behavioural
//   model (ownership turn, grant count, pending read, memory image) predicts
//   every output each cycle; a small RAM model drives ram_rdata.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          m0_req = 1'b0, m1_req = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_we = 1'b0, m1_we = 1'b0;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [DW-1:0] ram_rdata = '0;
  logic [1:0]    owner;

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .owner(owner)
  );

  function automatic logic [7:0] init_val(int i);
    if (i == 16) return 8'h5A;
    return 8'((i * 37) + 11);
  endfunction

  // Synchronous-read RAM: read-before-write, data one cycle after address.
  logic [7:0] mem [256];
  logic       ram_init_done = 1'b0;
  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int i = 0; i < 256; i++) mem[i] = init_val(i);
      ram_init_done = 1'b1;
    end
    ram_rdata = mem[ram_addr];
    if (ram_we) mem[ram_addr] = ram_wdata;
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int         checks = 0;
  int         failures = 0;
  int         m_owner;       // 0 none, 1 m0, 2 m1
  int         m_last;        // last owner index
  int         m_grants;      // grants given in the current turn
  bit         m_pend;
  int         m_tag;
  logic [7:0] m_pend_data;
  logic [7:0] exp_mem [256];

  logic       e_g0, e_g1, e_we, e_rv0, e_rv1;
  logic [7:0] e_addr, e_wdata, e_rd0, e_rd1;
  logic [1:0] e_owner;
  logic       last_g0, last_g1, last_rv0, last_rv1, last_we;
  logic [7:0] last_rd0, last_rd1, last_addr;
  logic [1:0] last_owner;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_outputs();
    e_g0    = reset && m_owner == 1 && m0_req;
    e_g1    = reset && m_owner == 2 && m1_req;
    e_addr  = e_g0 ? m0_addr  : (e_g1 ? m1_addr  : 8'h00);
    e_wdata = e_g0 ? m0_wdata : (e_g1 ? m1_wdata : 8'h00);
    e_we    = (e_g0 && m0_we) || (e_g1 && m1_we);
    e_rv0   = reset && m_pend && m_tag == 0;
    e_rv1   = reset && m_pend && m_tag == 1;
    e_rd0   = e_rv0 ? m_pend_data : 8'h00;
    e_rd1   = e_rv1 ? m_pend_data : 8'h00;
    e_owner = !reset ? 2'b00 : (m_owner == 1 ? 2'b01 : (m_owner == 2 ? 2'b10 : 2'b00));
  endtask

  task automatic model_reset();
    m_owner = 0; m_last = 1; m_grants = 0; m_pend = 0; m_tag = 0;
    m_pend_data = 8'h00;
  endtask

  task automatic model_update();
    int k;
    bit mine, other;
    if (!reset) begin
      model_reset();
      return;
    end
    m_pend      = (e_g0 && !m0_we) || (e_g1 && !m1_we);
    m_tag       = e_g1 ? 1 : 0;
    m_pend_data = exp_mem[e_addr];
    if (e_we) exp_mem[e_addr] = e_wdata;
    if (m_owner == 0) begin
      if (m0_req && m1_req) m_owner = (m_last == 1) ? 1 : 2;
      else if (m0_req)      m_owner = 1;
      else if (m1_req)      m_owner = 2;
    end else begin
      k     = m_owner - 1;
      mine  = (k == 0) ? m0_req : m1_req;
      other = (k == 0) ? m1_req : m0_req;
      if (!mine) begin
        m_owner  = other ? ((k == 0) ? 2 : 1) : 0;
        m_last   = k;
        m_grants = 0;
      end else begin
        m_grants++;
        if (m_grants >= MB && other) begin
          m_owner  = (k == 0) ? 2 : 1;
          m_last   = k;
          m_grants = 0;
        end
      end
    end
  endtask

  // One clock: compare all outputs mid-cycle, then advance the model.
  task automatic step();
    @(negedge clk);
    model_outputs();
    last_g0 = m0_gnt;  last_g1 = m1_gnt;  last_rv0 = m0_rvalid; last_rv1 = m1_rvalid;
    last_rd0 = m0_rdata; last_rd1 = m1_rdata; last_we = ram_we; last_addr = ram_addr;
    last_owner = owner;
    check("m0_gnt",    32'(m0_gnt),    32'(e_g0));
    check("m1_gnt",    32'(m1_gnt),    32'(e_g1));
    check("ram_addr",  32'(ram_addr),  32'(e_addr));
    check("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
    check("ram_we",    32'(ram_we),    32'(e_we));
    check("m0_rvalid", 32'(m0_rvalid), 32'(e_rv0));
    check("m1_rvalid", 32'(m1_rvalid), 32'(e_rv1));
    check("m0_rdata",  32'(m0_rdata),  32'(e_rd0));
    check("m1_rdata",  32'(m1_rdata),  32'(e_rd1));
    check("owner",     32'(owner),     32'(e_owner));
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) exp_mem[i] = init_val(i);
    model_reset();
    @(posedge clk);
    #1;

    // Reset state
    step();
    check("rst_owner", 32'(last_owner), 32'h0);
    check("rst_gnt",   32'({last_g0, last_g1}), 32'h0);

    // Single m0 read of 0x10 after release
    reset = 1'b1; m0_req = 1'b1; m0_addr = 8'h10; m0_we = 1'b0;
    step();
    check("tp1_arb_cycle", 32'(last_g0), 32'h0);
    step();
    check("tp1_gnt", 32'(last_g0), 32'h1);
    m0_req = 1'b0;
    step();
    check("tp1_rvalid", 32'(last_rv0), 32'h1);
    check("tp1_rdata",  32'(last_rd0), 32'h5A);
    check("tp1_owner",  32'(last_owner), 32'h1);
    step();

    // Contention from reset: 4 grants each, alternating, no idle cycle
    reset = 1'b0; step(); reset = 1'b1;
    m0_req = 1'b1; m0_addr = 8'h40; m1_req = 1'b1; m1_addr = 8'h80; m1_we = 1'b0;
    step();
    for (int i = 0; i < 16; i++) begin
      step();
      check("burst_m0", 32'(last_g0), 32'((i % 8) < 4));
      check("burst_m1", 32'(last_g1), 32'((i % 8) >= 4));
      if (e_g0) m0_addr = m0_addr + 8'd1;
      if (e_g1) m1_addr = m1_addr + 8'd1;
    end

    // Both idle
    m0_req = 1'b0; m1_req = 1'b0;
    step(); step();
    check("idle_owner", 32'(last_owner), 32'h0);
    check("idle_we",    32'(last_we),    32'h0);
    check("idle_addr",  32'(last_addr),  32'h0);

    // m1 writes 0xA5 to 0x20, then m0 reads it back
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 8'h20; m1_wdata = 8'hA5;
    step(); step();
    check("wr_gnt", 32'(last_g1), 32'h1);
    check("wr_we",  32'(last_we), 32'h1);
    m1_req = 1'b0; m1_we = 1'b0;
    m0_req = 1'b1; m0_addr = 8'h20; m0_we = 1'b0;
    step();
    check("wr_handover_gap", 32'({last_g0, last_g1}), 32'h0);
    step();
    check("rd_gnt", 32'(last_g0), 32'h1);
    check("rd_we",  32'(last_we), 32'h0);
    m0_req = 1'b0;
    step();
    check("rd_back", 32'(last_rd0), 32'hA5);

    // m0 releases while m1 waits: one cycle without grant, then m1
    m0_req = 1'b1; m0_addr = 8'h05;
    step(); step();
    m1_req = 1'b1; m1_addr = 8'h33; m1_we = 1'b0;
    step();
    m0_req = 1'b0;
    step();
    check("drop_gap", 32'({last_g0, last_g1}), 32'h0);
    step();
    check("drop_m1", 32'(last_g1), 32'h1);

    // Reset while m1 owns with a read pending
    reset = 1'b0;
    step();
    check("rstmid_rvalid", 32'(last_rv1), 32'h0);
    step();
    check("rstmid_owner", 32'(last_owner), 32'h0);
    check("rstmid_gnt",   32'({last_g0, last_g1, last_we}), 32'h0);
    check("rstmid_rv",    32'(last_rv1), 32'h0);
    reset = 1'b1; m0_req = 1'b1; m1_req = 1'b1;
    step(); step();
    check("rstmid_tie_m0", 32'({last_g0, last_g1}), 32'h2);
    m0_req = 1'b0; m1_req = 1'b0;
    step(); step();

    // Random traffic: each master holds a request until the model grants it
    for (int c = 0; c < 400; c++) begin
      step();
      if (!m0_req || e_g0) begin
        m0_req   = ($urandom_range(0, 3) != 0);
        m0_addr  = 8'($urandom_range(0, 15));
        m0_we    = $urandom_range(0, 1) == 1;
        m0_wdata = 8'($urandom);
      end
      if (!m1_req || e_g1) begin
        m1_req   = ($urandom_range(0, 3) != 0);
        m1_addr  = 8'($urandom_range(0, 15));
        m1_we    = $urandom_range(0, 1) == 1;
        m1_wdata = 8'($urandom);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
